// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its sequential dump reader:
// default widths and the dump FSM state encoding.
package regfile_pkg;

  localparam int REGFILE_N = 16;
  localparam int REGFILE_R = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks every register through one read port and streams (address, data)
// pairs on a valid/ready interface, with abort and a one-cycle done pulse.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int N         = REGFILE_N,
  parameter int R         = REGFILE_R,
  parameter int SKIP_ZERO = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  output logic [R-1:0] readAddr,
  input  logic [N-1:0] readData,
  output logic [N-1:0] outData,
  output logic [R-1:0] outAddr,
  output logic         outValid,
  input  logic         outReady,
  output logic         busy,
  output logic         done
);

  localparam logic [R-1:0] FIRST_ADDR = (SKIP_ZERO != 0) ? R'(1) : R'(0);
  localparam logic [R-1:0] LAST_ADDR  = '1;

  dump_state_t  state_reg;
  logic [R-1:0] count_reg;
  logic [N-1:0] data_reg;
  logic [R-1:0] addr_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      data_reg  <= '0;
      addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            count_reg <= FIRST_ADDR;
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            state_reg <= IDLE;
          end else begin
            data_reg  <= readData;
            addr_reg  <= count_reg;
            state_reg <= SEND;
          end
        end
        SEND: begin
          // abort outranks the handshake; the terminal compare keeps the counter from wrapping
          if (abort) begin
            state_reg <= IDLE;
          end else if (outReady) begin
            if (count_reg == LAST_ADDR) begin
              state_reg <= DONE;
            end else begin
              count_reg <= count_reg + 1'b1;
              state_reg <= FETCH;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign readAddr = count_reg;
  assign outData  = data_reg;
  assign outAddr  = addr_reg;
  assign outValid = (state_reg == SEND);
  assign busy     = (state_reg == FETCH) || (state_reg == SEND);
  assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full dump, backpressure, SKIP_ZERO, abort,
// ignored restart and asynchronous reset mid-dump.
module tb_regfile_dump;

  logic        clock;
  logic        reset;
  logic        start0, start1, abort, outReady;
  logic [2:0]  readAddr0, readAddr1, outAddr0, outAddr1;
  logic [15:0] readData0, readData1, outData0, outData1;
  logic        outValid0, outValid1, busy0, busy1, done0, done1;

  logic [15:0] regs     [8];
  logic [15:0] exp_data [8];
  int          cyc;
  int          checks;
  int          failures;

  assign readData0 = regs[readAddr0];
  assign readData1 = regs[readAddr1];

  regfile_dump #(.N(16), .R(3), .SKIP_ZERO(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort),
    .readAddr(readAddr0), .readData(readData0), .outData(outData0),
    .outAddr(outAddr0), .outValid(outValid0), .outReady(outReady),
    .busy(busy0), .done(done0)
  );

  regfile_dump #(.N(16), .R(3), .SKIP_ZERO(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .abort(1'b0),
    .readAddr(readAddr1), .readData(readData1), .outData(outData1),
    .outAddr(outAddr1), .outValid(outValid1), .outReady(outReady),
    .busy(busy1), .done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one dump on the selected instance from a negedge; returns at a negedge in IDLE.
  task automatic run_dump(input bit sel, input int stall_addr, input int stall_n,
                          input bit restart, input string tag);
    int       k, words, dones, done_edge, stalled, first;
    bit       finished;
    logic     v, dn, b;
    logic [2:0]  a;
    logic [15:0] d;
    first = sel ? 1 : 0;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
    words = 0; dones = 0; done_edge = -1; stalled = 0; finished = 1'b0;
    for (int budget = 0; budget < 80 && !finished; budget++) begin
      v  = sel ? outValid1 : outValid0;
      a  = sel ? outAddr1  : outAddr0;
      d  = sel ? outData1  : outData0;
      dn = sel ? done1     : done0;
      b  = sel ? busy1     : busy0;
      if (!sel && restart) start0 = (budget == 5 || budget == 6);
      if (v && (int'(a) == stall_addr) && (stalled < stall_n)) begin
        outReady = 1'b0;
        stalled++;
        chk({tag, "_stall_data"}, {16'h0, d}, {16'h0, exp_data[stall_addr]});
        chk({tag, "_stall_addr"}, {29'h0, a}, stall_addr);
      end else begin
        outReady = 1'b1;
      end
      if (v && outReady) begin
        chk({tag, "_addr"}, {29'h0, a}, first + words);
        chk({tag, "_data"}, {16'h0, d}, {16'h0, exp_data[(first + words) % 8]});
        if (stall_n == 0) chk({tag, "_accept_edge"}, cyc + 1, k + 2 + 2 * words);
        words++;
      end
      if (dn) begin
        dones++;
        done_edge = cyc;
      end
      if (done_edge >= 0 && !dn && !b) finished = 1'b1;
      if (!finished) @(negedge clock);
    end
    outReady = 1'b1;
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_words"}, words, 8 - first);
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_done_edge"}, done_edge, k + 2 * (8 - first) + stall_n);
    chk({tag, "_idle_valid"}, sel ? outValid1 : outValid0, 0);
    $display("dump %s sel=%0d words=%0d dones=%0d done_edge=%0d k=%0d", tag, sel, words, dones, done_edge, k);
  endtask

  initial begin
    bit seen;
    checks = 0; failures = 0;
    exp_data = '{16'h0000, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 16'hf132, 16'h0000, 16'hff42};
    for (int i = 0; i < 8; i++) regs[i] = exp_data[i];
    start0 = 1'b0; start1 = 1'b0; abort = 1'b0; outReady = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_valid", outValid0, 0);
    chk("rst_done", done0, 0);
    chk("rst_data", {16'h0, outData0}, 0);
    chk("rst_addr", {29'h0, outAddr0}, 0);
    chk("rst_readaddr", {29'h0, readAddr0}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", busy0, 0);

    run_dump(1'b0, -1, 0, 1'b0, "full");
    run_dump(1'b0, 5, 3, 1'b0, "bp");
    run_dump(1'b1, -1, 0, 1'b0, "skip0");
    run_dump(1'b0, -1, 0, 1'b1, "restart");

    // abort in SEND of address 3
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (outValid0 && outAddr0 == 3'd3) seen = 1'b1;
      else @(negedge clock);
    end
    chk("abort_reach", seen, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_valid", outValid0, 0);
    chk("abort_busy", busy0, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done0 || busy0) seen = 1'b1;
      @(negedge clock);
    end
    chk("abort_no_done", seen, 0);
    $display("abort at addr 3 handled");
    run_dump(1'b0, -1, 0, 1'b0, "after_abort");

    // asynchronous reset during the FETCH of address 4
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy0 && !outValid0 && readAddr0 == 3'd4) seen = 1'b1;
      else @(negedge clock);
    end
    chk("reset_reach", seen, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_valid", outValid0, 0);
    chk("arst_done", done0, 0);
    chk("arst_data", {16'h0, outData0}, 0);
    chk("arst_addr", {29'h0, outAddr0}, 0);
    chk("arst_readaddr", {29'h0, readAddr0}, 0);
    $display("async reset applied mid-dump");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_done", done0, 0);
    run_dump(1'b0, -1, 0, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
